// File: rtl/wn_pdcchrx_pkg.sv
// Shared definitions for the PDCCH RX angle repeater arbiter: config field layout,
// FSM states, stream select encoding and the expected pass length.
package wn_pdcchrx_pkg;

  localparam int unsigned CNT_W       = 9;
  localparam int unsigned CFG_INT_BIT = 8;
  localparam int unsigned CFG_PRB_MSB = 7;
  localparam int unsigned CFG_PRB_LSB = 2;
  localparam int unsigned CFG_SYM_MSB = 1;
  localparam int unsigned CFG_SYM_LSB = 0;

  localparam logic SEL_TOE = 1'b0;
  localparam logic SEL_FOE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARB   = 3'd1,
    ST_CFG   = 3'd2,
    ST_FWD   = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  // Beats per pass: 6 per PRB when interleaved, otherwise one per PRB per symbol.
  function automatic logic [CNT_W-1:0] exp_len(input logic [8:0] cfg);
    logic [5:0] prb;
    logic [1:0] sym;
    prb = cfg[CFG_PRB_MSB:CFG_PRB_LSB];
    sym = cfg[CFG_SYM_MSB:CFG_SYM_LSB];
    if (cfg[CFG_INT_BIT]) exp_len = CNT_W'(prb) * CNT_W'(6);
    else                  exp_len = CNT_W'(prb) * CNT_W'(sym);
  endfunction

endpackage

// File: rtl/wn_pdcchrx_angle_repeater_arb_rr_arb2.sv
// Two-way round-robin grant; ptr names the requester preferred on a tie.
module wn_pdcchrx_rr_arb2
  import wn_pdcchrx_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = (ptr == SEL_FOE) ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/wn_pdcchrx_angle_repeater_arb.sv
// Sequences one TOE pass and one FOE pass per config through a shared angle repeater,
// forwarding the granted stream and checking pass length and drain completion.
module wn_pdcchrx_angle_repeater_arb
  import wn_pdcchrx_pkg::*;
#(
  parameter int unsigned DW = 48,
  parameter int unsigned CW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] cfg_in_tdata,
  input  logic          cfg_in_tvalid,
  output logic          cfg_in_tready,
  input  logic [DW-1:0] toe_in_tdata,
  input  logic          toe_in_tvalid,
  output logic          toe_in_tready,
  input  logic          toe_in_tlast,
  input  logic [DW-1:0] foe_in_tdata,
  input  logic          foe_in_tvalid,
  output logic          foe_in_tready,
  input  logic          foe_in_tlast,
  output logic [CW-1:0] rep_cfg_tdata,
  output logic          rep_cfg_tvalid,
  input  logic          rep_cfg_tready,
  output logic [DW-1:0] rep_data_tdata,
  output logic          rep_data_tvalid,
  input  logic          rep_data_tready,
  output logic          rep_data_tlast,
  input  logic          rep_out_tvalid,
  input  logic          rep_out_tready,
  input  logic          rep_out_tlast,
  output logic          sel_out,
  output logic          busy,
  output logic          cfg_err,
  output logic          len_err
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cfg;
  logic [CNT_W-1:0] r_exp;
  logic [CNT_W-1:0] r_beat_cnt;
  logic [1:0]       r_drain_cnt;
  logic [1:0]       r_done;
  logic             r_ptr;
  logic             r_sel;
  logic             r_rep_cfg_tvalid;
  logic             r_cfg_err;
  logic             r_len_err;
  logic             r_busy;

  logic       w_cfg_hs;
  logic       w_cfg_bad;
  logic [1:0] w_req;
  logic [1:0] w_gnt;
  logic       w_grant;
  logic       w_rep_cfg_hs;
  logic       w_beat_hs;
  logic       w_last_hs;
  logic       w_drain_hs;
  logic       w_drain_end;
  logic [1:0] w_done_nxt;

  assign w_cfg_hs     = cfg_in_tvalid & cfg_in_tready;
  assign w_cfg_bad    = (cfg_in_tdata[CFG_SYM_MSB:CFG_SYM_LSB] == 2'd0) ||
                        (cfg_in_tdata[CFG_PRB_MSB:CFG_PRB_LSB] == 6'd0);
  assign w_req        = {~r_done[1] & foe_in_tvalid, ~r_done[0] & toe_in_tvalid};
  assign w_grant      = (r_state == ST_ARB) && (|w_gnt);
  assign w_rep_cfg_hs = r_rep_cfg_tvalid & rep_cfg_tready;
  assign w_beat_hs    = rep_data_tvalid & rep_data_tready;
  assign w_last_hs    = w_beat_hs & rep_data_tlast;
  assign w_drain_hs   = (r_state == ST_DRAIN) & rep_out_tvalid & rep_out_tready & rep_out_tlast;
  assign w_drain_end  = w_drain_hs &&
                        (2'(r_drain_cnt + 2'd1) == r_cfg[CFG_SYM_MSB:CFG_SYM_LSB]);
  assign w_done_nxt   = r_done | (2'b01 << r_sel);

  wn_pdcchrx_rr_arb2 u_rr_arb2 (
    .req (w_req),
    .ptr (r_ptr),
    .gnt (w_gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_cfg_hs && !w_cfg_bad) w_state_nxt = ST_ARB;
      ST_ARB:   if (|w_gnt) w_state_nxt = ST_CFG;
      ST_CFG:   if (w_rep_cfg_hs) w_state_nxt = ST_FWD;
      ST_FWD:   if (w_last_hs) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_drain_end) w_state_nxt = (&w_done_nxt) ? ST_IDLE : ST_ARB;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Zero-latency pass-through of the granted stream; every ready is held low in reset.
  always_comb begin
    cfg_in_tready   = 1'b0;
    toe_in_tready   = 1'b0;
    foe_in_tready   = 1'b0;
    rep_data_tvalid = 1'b0;
    rep_data_tdata  = toe_in_tdata;
    rep_data_tlast  = toe_in_tlast;
    if (r_sel == SEL_FOE) begin
      rep_data_tdata = foe_in_tdata;
      rep_data_tlast = foe_in_tlast;
    end
    if (!rst) begin
      cfg_in_tready = (r_state == ST_IDLE);
      if (r_state == ST_FWD) begin
        if (r_sel == SEL_FOE) begin
          rep_data_tvalid = foe_in_tvalid;
          foe_in_tready   = rep_data_tready;
        end else begin
          rep_data_tvalid = toe_in_tvalid;
          toe_in_tready   = rep_data_tready;
        end
      end
    end
  end

  // The tie pointer moves only on the first grant of a job, so consecutive jobs alternate
  // which angle stream goes first.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg            <= '0;
      r_exp            <= '0;
      r_beat_cnt       <= '0;
      r_drain_cnt      <= '0;
      r_done           <= '0;
      r_ptr            <= SEL_TOE;
      r_sel            <= SEL_TOE;
      r_rep_cfg_tvalid <= 1'b0;
      r_cfg_err        <= 1'b0;
      r_len_err        <= 1'b0;
      r_busy           <= 1'b0;
    end else begin
      r_cfg_err <= w_cfg_hs & w_cfg_bad;
      r_len_err <= w_last_hs && (CNT_W'(r_beat_cnt + 9'd1) != r_exp);
      r_busy    <= (w_state_nxt != ST_IDLE);
      if (w_cfg_hs) begin
        r_cfg  <= cfg_in_tdata;
        r_exp  <= exp_len(9'(cfg_in_tdata));
        r_done <= '0;
      end
      if (w_grant) begin
        r_sel <= w_gnt[1] ? SEL_FOE : SEL_TOE;
        if (r_done == 2'b00) r_ptr <= w_gnt[1] ? SEL_TOE : SEL_FOE;
      end
      if (w_grant)           r_rep_cfg_tvalid <= 1'b1;
      else if (w_rep_cfg_hs) r_rep_cfg_tvalid <= 1'b0;
      if (w_beat_hs) r_beat_cnt <= w_last_hs ? '0 : CNT_W'(r_beat_cnt + 9'd1);
      if (w_drain_hs) begin
        if (w_drain_end) begin
          r_drain_cnt <= '0;
          r_done      <= w_done_nxt;
        end else begin
          r_drain_cnt <= 2'(r_drain_cnt + 2'd1);
        end
      end
    end
  end

  assign rep_cfg_tdata  = r_cfg;
  assign rep_cfg_tvalid = r_rep_cfg_tvalid;
  assign sel_out        = r_sel;
  assign busy           = r_busy;
  assign cfg_err        = r_cfg_err;
  assign len_err        = r_len_err;

endmodule
